if_stage_fetch: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the control decoder.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Captures responses into IF/ID; decode takes its opcode field from if_id_instr[31:21].
- Handles decode-stage stall (with a one-entry hold buffer) and branch redirect (flush with bubble plus discard of in-flight fetch).

---
 rtl/if_stage_fetch.sv | 157 +++++++++++++++
 tb/tb_if_stage_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC and allows one instruction-memory request in flight at a time.
// Fetched words are captured into IF/ID for the decoder. A decode stall is
// absorbed by a one-entry hold buffer. A taken branch redirects the PC,
// inserts a bubble and discards any fetch still in flight.
module if_stage_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  output logic [31:0] if_id_instr_o,
  output logic [63:0] if_id_pc_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {StIssue, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [63:0] br_target_aligned;
  logic [63:0] pc_inc;

  // Branch targets are word aligned; the low two bits are dropped.
  assign br_target_aligned = {br_target_i[63:2], 2'b00};
  // Sequential PC wraps modulo 2^64.
  assign pc_inc            = pc_q + 64'd4;

  // Request is gated by reset so it drops the moment reset is asserted.
  assign imem_req_o    = (state_q == StIssue) && !br_taken_i && !reset_i;
  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_valid_o = if_id_valid_q;

  // Next-state: fetch sequencing, stall hold, branch flush and stale-response drop.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_valid_d  = hold_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;

    unique case (state_q)
      StIssue: begin
        // A response strobe here is a protocol error and is ignored.
        if (br_taken_i) begin
          pc_d          = br_target_aligned;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (br_taken_i) begin
          // Branch wins over both the response and a stall.
          pc_d          = br_target_aligned;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          state_d       = imem_rvalid_i ? StIssue : StDrop;
        end else if (imem_rvalid_i) begin
          pc_d = pc_inc;
          if (stall_i) begin
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = pc_q;
            hold_valid_d = 1'b1;
            state_d      = StHold;
          end else begin
            if_id_instr_d = imem_rdata_i;
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
            state_d       = StIssue;
          end
        end else if (!stall_i) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end

      StHold: begin
        if (br_taken_i) begin
          // The held instruction is younger than the branch: squash it.
          hold_valid_d  = 1'b0;
          pc_d          = br_target_aligned;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          state_d       = StIssue;
        end else if (!stall_i) begin
          if_id_instr_d = hold_instr_q;
          if_id_pc_d    = hold_pc_q;
          if_id_valid_d = 1'b1;
          hold_valid_d  = 1'b0;
          state_d       = StIssue;
        end
      end

      StDrop: begin
        // Waiting for the stale response of the squashed fetch.
        if (br_taken_i) begin
          pc_d = br_target_aligned;
        end
        if (imem_rvalid_i) begin
          state_d = StIssue;
        end
        if (!stall_i) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end

      default: state_d = StIssue;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIssue;
      pc_q          <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 64'h0;
      hold_valid_q  <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= 64'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      hold_valid_q  <= hold_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboarded bench for if_stage_fetch: directed scenarios then random traffic
// against a transaction-level model of the fetch stage and instruction memory.
module tb_if_stage_fetch;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;

  if_stage_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .imem_rvalid_i(imem_rvalid),
    .if_id_instr_o(if_id_instr),
    .if_id_pc_o   (if_id_pc),
    .if_id_valid_o(if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
  } snap_t;

  typedef struct {
    int unsigned due;
    logic [63:0] addr;
  } pend_t;

  snap_t exp_q[$];
  pend_t pend_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  int unsigned spur_pct = 0;
  bit          late_rv = 1'b0;

  // Reference model: fetch-stage view as "fetch outstanding / doomed / word held".
  logic [63:0] m_pc;
  bit          m_busy, m_doomed, m_held;
  logic [31:0] m_hold_instr, m_instr;
  logic [63:0] m_hold_pc, m_ifpc;
  bit          m_valid;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h9100_0421;
    if (a == 64'h4) return 32'h8B02_0020;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 0; m_doomed = 0; m_held = 0;
    m_hold_instr = NOP_INSTR; m_hold_pc = 64'h0;
    m_instr = NOP_INSTR; m_ifpc = 64'h0; m_valid = 0;
  endtask

  task automatic bubble();
    m_instr = NOP_INSTR;
    m_valid = 0;
  endtask

  // One clock of stimulus: drive inputs, queue the expected outputs, advance the model.
  task automatic cycle(input bit rst, input bit st, input bit br, input logic [63:0] tgt);
    bit          rv;
    logic [31:0] rd;
    logic [63:0] t;
    snap_t       e;
    @(posedge clk);
    #1;
    cyc++;
    rv = 0;
    rd = $urandom;
    if (!rst) begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rv = 1;
        rd = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else if (late_rv || (!m_busy && ($urandom_range(99) < spur_pct))) begin
        rv = 1;
      end
    end
    late_rv     = 0;
    reset       = rst;
    stall       = st;
    br_taken    = br;
    br_target   = tgt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    if (rst) begin
      model_reset();
      pend_q.delete();
      e = '{req: 1'b0, addr: m_pc, instr: m_instr, pc: m_ifpc, valid: m_valid};
      exp_q.push_back(e);
    end else begin
      e = '{req: (!m_busy && !m_held && !br), addr: m_pc, instr: m_instr, pc: m_ifpc,
            valid: m_valid};
      exp_q.push_back(e);
      if (e.req) pend_q.push_back('{due: cyc + mem_lat, addr: m_pc});
      t = {tgt[63:2], 2'b00};
      if (m_held) begin
        if (br) begin
          m_held = 0; m_pc = t; bubble();
        end else if (!st) begin
          m_instr = m_hold_instr; m_ifpc = m_hold_pc; m_valid = 1; m_held = 0;
        end
      end else if (!m_busy) begin
        if (br) begin
          m_pc = t; bubble();
        end else begin
          m_busy = 1; m_doomed = 0;
        end
      end else if (m_doomed) begin
        if (br) m_pc = t;
        if (rv) begin
          m_busy = 0; m_doomed = 0;
        end
        if (!st) bubble();
      end else begin
        if (br) begin
          m_pc = t; bubble();
          if (rv) m_busy = 0;
          else m_doomed = 1;
        end else if (rv) begin
          m_busy = 0;
          if (st) begin
            m_held = 1; m_hold_instr = rd; m_hold_pc = m_pc;
          end else begin
            m_instr = rd; m_ifpc = m_pc; m_valid = 1;
          end
          m_pc = m_pc + 64'd4;
        end else if (!st) begin
          bubble();
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 64'h0);
  endtask

  // Monitor: pops the expected snapshot for each cycle and compares mid-cycle.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (imem_req !== e.req || imem_addr !== e.addr || if_id_instr !== e.instr ||
            if_id_pc !== e.pc || if_id_valid !== e.valid) begin
          n_err++;
          $display("FAIL outputs t=%0t: got req=%b addr=%h instr=%h pc=%h valid=%b, want req=%b addr=%h instr=%h pc=%h valid=%b",
                   $time, imem_req, imem_addr, if_id_instr, if_id_pc, if_id_valid,
                   e.req, e.addr, e.instr, e.pc, e.valid);
        end
      end
    end
  end

  initial begin
    model_reset();

    // Straight-line fetch from reset, then a stall as the 0x8 response lands.
    mem_lat = 1;
    cycle(1, 0, 0, 64'h0);
    cycle(1, 0, 0, 64'h0);
    idle(5);
    cycle(0, 1, 0, 64'h0);
    cycle(0, 1, 0, 64'h0);
    idle(4);

    // Reset while waiting on a fetch at 0x40; its late response must be ignored.
    mem_lat = 4;
    cycle(1, 0, 0, 64'h0);
    cycle(0, 0, 1, 64'h40);
    idle(2);
    cycle(1, 0, 0, 64'h0);
    late_rv = 1;
    mem_lat = 1;
    idle(4);

    // Branch while waiting with no response yet; stale response is discarded.
    mem_lat = 3;
    cycle(1, 0, 0, 64'h0);
    idle(1);
    cycle(0, 0, 1, 64'h103);
    idle(6);

    // Branch and stall together while holding a word.
    mem_lat = 1;
    cycle(1, 0, 0, 64'h0);
    idle(1);
    cycle(0, 1, 0, 64'h0);
    cycle(0, 1, 1, 64'h2000);
    idle(4);

    // PC wrap past the top of the address space.
    cycle(1, 0, 0, 64'h0);
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(5);

    // Random traffic with variable latency and stray response strobes.
    spur_pct = 15;
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] tgt;
      mem_lat = $urandom_range(1, 3);
      tgt = {$urandom, $urandom};
      if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      cycle(($urandom_range(199) == 0), ($urandom_range(9) < 3), ($urandom_range(9) == 0), tgt);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked snapshots, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
